// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS decode stage: opcodes, ALU op classes,
// instruction field positions and the control-word decode.
package mips16_pkg;

    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;
    localparam int OP_W       = 3;
    localparam int FUNCT_W    = 4;
    localparam int IMM_W      = 7;

    localparam int OP_LSB = 13;
    localparam int RS_LSB = 10;
    localparam int RT_LSB = 7;
    localparam int RD_LSB = 4;

    localparam logic [OP_W-1:0] OP_R    = 3'd0;
    localparam logic [OP_W-1:0] OP_ADDI = 3'd1;
    localparam logic [OP_W-1:0] OP_ORI  = 3'd2;
    localparam logic [OP_W-1:0] OP_SLTI = 3'd3;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'd4;
    localparam logic [OP_W-1:0] OP_BNE  = 3'd5;
    localparam logic [OP_W-1:0] OP_LW   = 3'd6;
    localparam logic [OP_W-1:0] OP_SW   = 3'd7;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_IMM = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic       regdst;
        logic       regwrite;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_R: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_R;
            end
            OP_ADDI, OP_ORI, OP_SLTI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_IMM;
            end
            OP_BEQ, OP_BNE: begin
                c.branch = 1'b1;
                c.aluop  = ALUOP_IMM;
            end
            OP_LW: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.aluop    = ALUOP_MEM;
            end
            default: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
                c.aluop    = ALUOP_MEM;
            end
        endcase
        return c;
    endfunction

    // Only these formats actually consume rt as a source operand.
    function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
        return (op == OP_R) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/WB-facing inputs and ID/EX-facing outputs of the decode stage, bundled as one bus.
interface id_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    import mips16_pkg::*;

    logic                  id_valid;
    logic [INSTR_W-1:0]    instin;
    logic [PC_W-1:0]       pc_in;
    logic                  wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  flush;

    logic                  stall;
    logic                  ex_valid;
    logic [PC_W-1:0]       ex_pc;
    logic [DATA_W-1:0]     ex_rd1;
    logic [DATA_W-1:0]     ex_rd2;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [OP_W-1:0]       ex_opcode;
    logic [FUNCT_W-1:0]    ex_funct;
    logic                  regdst;
    logic                  regwrite;
    logic                  alusrc;
    logic                  branch;
    logic                  memwrite;
    logic                  memread;
    logic                  memtoreg;
    logic [1:0]            aluop;

    modport master (
        output id_valid, instin, pc_in, wb_regwrite, wb_addr, wb_data, flush,
        input  stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_opcode, ex_funct, regdst, regwrite, alusrc, branch, memwrite,
               memread, memtoreg, aluop
    );

    modport slave (
        input  id_valid, instin, pc_in, wb_regwrite, wb_addr, wb_data, flush,
        output stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_opcode, ex_funct, regdst, regwrite, alusrc, branch, memwrite,
               memread, memtoreg, aluop
    );

endinterface

// File: rtl/id_regfile.sv
// Two-read, one-write register file with hard-wired zero register and
// write-through bypass so WB and ID can share a cycle.
module id_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr1,
    input  logic [2:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 3'd0) && (int'(waddr) < NREGS)) begin
            mem[waddr] <= wdata;
        end
    end

    // A nonzero read address that matches an active write sees the new data this cycle.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if ((raddr1 != 3'd0) && (int'(raddr1) < NREGS)) begin
            rdata1 = (we && (waddr == raddr1)) ? wdata : mem[raddr1];
        end
        if ((raddr2 != 3'd0) && (int'(raddr2) < NREGS)) begin
            rdata2 = (we && (waddr == raddr2)) ? wdata : mem[raddr2];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS16 instruction-decode stage: field split, control decode, sign extension,
// load-use stall detection and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int PC_W   = 16
) (
    input logic         clk,
    input logic         reset,
    id_stage_pipe_if.slave bus
);
    import mips16_pkg::*;

    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_W-1:0]     imm, rd1, rd2;
    ctrl_t                 ctrl;
    logic                  load_use, bubble;

    logic                  ex_valid_q;
    logic [PC_W-1:0]       ex_pc_q;
    logic [DATA_W-1:0]     ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
    logic [OP_W-1:0]       ex_op_q;
    logic [FUNCT_W-1:0]    ex_funct_q;
    ctrl_t                 ex_ctrl_q;

    assign op    = bus.instin[OP_LSB +: OP_W];
    assign rs    = bus.instin[RS_LSB +: REG_ADDR_W];
    assign rt    = bus.instin[RT_LSB +: REG_ADDR_W];
    assign rd    = bus.instin[RD_LSB +: REG_ADDR_W];
    assign funct = bus.instin[FUNCT_W-1:0];
    assign imm   = {{(DATA_W-IMM_W){bus.instin[IMM_W-1]}}, bus.instin[IMM_W-1:0]};
    assign ctrl  = decode_ctrl(op);

    id_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (bus.wb_regwrite),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // A load in EX whose target feeds this instruction cannot be forwarded in time.
    assign load_use = ex_valid_q & ex_ctrl_q.memread & (ex_rt_q != '0) & bus.id_valid &
                      ((ex_rt_q == rs) | ((ex_rt_q == rt) & op_uses_rt(op)));
    assign bubble   = bus.flush | load_use | ~bus.id_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_op_q    <= '0;
            ex_funct_q <= '0;
            ex_ctrl_q  <= '0;
        end else if (bubble) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_op_q    <= '0;
            ex_funct_q <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= 1'b1;
            ex_pc_q    <= bus.pc_in;
            ex_rd1_q   <= rd1;
            ex_rd2_q   <= rd2;
            ex_imm_q   <= imm;
            ex_rs_q    <= rs;
            ex_rt_q    <= rt;
            ex_rd_q    <= rd;
            ex_op_q    <= op;
            ex_funct_q <= funct;
            ex_ctrl_q  <= ctrl;
        end
    end

    assign bus.stall     = load_use;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_pc     = ex_pc_q;
    assign bus.ex_rd1    = ex_rd1_q;
    assign bus.ex_rd2    = ex_rd2_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_rs     = ex_rs_q;
    assign bus.ex_rt     = ex_rt_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_opcode = ex_op_q;
    assign bus.ex_funct  = ex_funct_q;

    // Controls are qualified by valid so a bubble can never write state downstream.
    assign bus.regdst   = ex_valid_q & ex_ctrl_q.regdst;
    assign bus.regwrite = ex_valid_q & ex_ctrl_q.regwrite;
    assign bus.alusrc   = ex_valid_q & ex_ctrl_q.alusrc;
    assign bus.branch   = ex_valid_q & ex_ctrl_q.branch;
    assign bus.memwrite = ex_valid_q & ex_ctrl_q.memwrite;
    assign bus.memread  = ex_valid_q & ex_ctrl_q.memread;
    assign bus.memtoreg = ex_valid_q & ex_ctrl_q.memtoreg;
    assign bus.aluop    = ex_valid_q ? ex_ctrl_q.aluop : 2'b00;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Lock-step bench for 16- and 32-bit decode stages against an instruction-level
// model of the register file, decode table and load-use rule.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(16), .PC_W(16)) bus16 ();
    id_stage_pipe_if #(.DATA_W(32), .PC_W(16)) bus32 ();

    id_stage_pipe #(.DATA_W(16), .NREGS(8), .PC_W(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    id_stage_pipe #(.DATA_W(32), .NREGS(8), .PC_W(16)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Control vector {regdst,regwrite,alusrc,branch,memwrite,memread,memtoreg,aluop} per opcode.
    logic [8:0] ctrl_tbl [8] = '{9'b110000010, 9'b011000001, 9'b011000001, 9'b011000001,
                                 9'b000100001, 9'b000100001, 9'b011001100, 9'b001010000};

    logic [31:0] m_regs [8];
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic [31:0] m_rd1, m_rd2;
    logic        m_stall;
    logic        last_stall16;
    logic [15:0] pc_cnt;

    logic [8:0]  obs_ctrl16, obs_ctrl32;
    logic [15:0] obs_fields16, obs_fields32;

    assign obs_ctrl16 = {bus16.regdst, bus16.regwrite, bus16.alusrc, bus16.branch,
                         bus16.memwrite, bus16.memread, bus16.memtoreg, bus16.aluop};
    assign obs_ctrl32 = {bus32.regdst, bus32.regwrite, bus32.alusrc, bus32.branch,
                         bus32.memwrite, bus32.memread, bus32.memtoreg, bus32.aluop};
    assign obs_fields16 = {bus16.ex_opcode, bus16.ex_rs, bus16.ex_rt, bus16.ex_rd, bus16.ex_funct};
    assign obs_fields32 = {bus32.ex_opcode, bus32.ex_rs, bus32.ex_rt, bus32.ex_rd, bus32.ex_funct};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int field(input logic [15:0] instr, input int lsb);
        return (int'(instr) / (1 << lsb)) % 8;
    endfunction

    function automatic logic [31:0] sext7(input logic [15:0] instr);
        int v;
        v = int'(instr) % 128;
        if (v >= 64) v = v - 128;
        return 32'(v);
    endfunction

    function automatic logic [31:0] modelRead(input int addr, input logic we, input logic [2:0] waddr,
                                              input logic [31:0] wdata);
        if (addr == 0) return 32'd0;
        if (we && int'(waddr) == addr) return wdata;
        return m_regs[addr];
    endfunction

    task automatic compareAll();
        logic [8:0] exp_ctrl;
        exp_ctrl = m_valid ? ctrl_tbl[field(m_instr, 13)] : 9'd0;
        checkOutput("ex_valid16", 32'(bus16.ex_valid), 32'(m_valid));
        checkOutput("ex_valid32", 32'(bus32.ex_valid), 32'(m_valid));
        checkOutput("ctrl16", 32'(obs_ctrl16), 32'(exp_ctrl));
        checkOutput("ctrl32", 32'(obs_ctrl32), 32'(exp_ctrl));
        if (m_valid) begin
            checkOutput("ex_pc16", 32'(bus16.ex_pc), 32'(m_pc));
            checkOutput("ex_pc32", 32'(bus32.ex_pc), 32'(m_pc));
            checkOutput("ex_rd1_16", 32'(bus16.ex_rd1), 32'(m_rd1[15:0]));
            checkOutput("ex_rd2_16", 32'(bus16.ex_rd2), 32'(m_rd2[15:0]));
            checkOutput("ex_rd1_32", bus32.ex_rd1, m_rd1);
            checkOutput("ex_rd2_32", bus32.ex_rd2, m_rd2);
            checkOutput("ex_imm16", 32'(bus16.ex_imm), 32'(sext7(m_instr) & 32'h0000FFFF));
            checkOutput("ex_imm32", bus32.ex_imm, sext7(m_instr));
            checkOutput("fields16", 32'(obs_fields16), 32'(m_instr));
            checkOutput("fields32", 32'(obs_fields32), 32'(m_instr));
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus16.ex_valid) | 32'(bus32.ex_valid), 32'd0);
        checkOutput({tag, "_ctrl"}, 32'(obs_ctrl16) | 32'(obs_ctrl32), 32'd0);
        checkOutput({tag, "_stall"}, 32'(bus16.stall) | 32'(bus32.stall), 32'd0);
        checkOutput({tag, "_pc"}, 32'(bus16.ex_pc) | 32'(bus32.ex_pc), 32'd0);
        checkOutput({tag, "_data16"}, 32'(bus16.ex_rd1) | 32'(bus16.ex_rd2) | 32'(bus16.ex_imm), 32'd0);
        checkOutput({tag, "_data32"}, bus32.ex_rd1 | bus32.ex_rd2 | bus32.ex_imm, 32'd0);
        checkOutput({tag, "_fields"}, 32'(obs_fields16) | 32'(obs_fields32), 32'd0);
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic we,
                                 input logic [2:0] waddr, input logic [31:0] wdata, input logic fl);
        int op, rs, rt, ex_rt;
        logic [31:0] r1, r2;
        @(negedge clk);
        pc_cnt = pc_cnt + 16'd1;
        bus16.id_valid = v;      bus32.id_valid = v;
        bus16.instin = instr;    bus32.instin = instr;
        bus16.pc_in = pc_cnt;    bus32.pc_in = pc_cnt;
        bus16.wb_regwrite = we;  bus32.wb_regwrite = we;
        bus16.wb_addr = waddr;   bus32.wb_addr = waddr;
        bus16.wb_data = wdata[15:0];
        bus32.wb_data = wdata;
        bus16.flush = fl;        bus32.flush = fl;
        op = field(instr, 13);
        rs = field(instr, 10);
        rt = field(instr, 7);
        ex_rt = field(m_instr, 7);
        m_stall = m_valid && field(m_instr, 13) == 6 && ex_rt != 0 && v &&
                  (ex_rt == rs || (ex_rt == rt && (op == 0 || op == 4 || op == 5 || op == 7)));
        #1;
        last_stall16 = bus16.stall;
        checkOutput("stall16", 32'(bus16.stall), 32'(m_stall));
        checkOutput("stall32", 32'(bus32.stall), 32'(m_stall));
        @(posedge clk);
        r1 = modelRead(rs, we, waddr, wdata);
        r2 = modelRead(rt, we, waddr, wdata);
        if (fl || m_stall || !v) begin
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_instr = instr;
            m_pc    = pc_cnt;
            m_rd1   = r1;
            m_rd2   = r2;
        end
        if (we && waddr != 3'd0) m_regs[waddr] = wdata;
        #1;
        compareAll();
    endtask

    task automatic modelClear();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0;
        m_instr = 16'd0;
        m_stall = 1'b0;
    endtask

    task automatic driveIdle();
        bus16.id_valid = 1'b0;    bus32.id_valid = 1'b0;
        bus16.instin = 16'd0;     bus32.instin = 16'd0;
        bus16.pc_in = 16'd0;      bus32.pc_in = 16'd0;
        bus16.wb_regwrite = 1'b0; bus32.wb_regwrite = 1'b0;
        bus16.wb_addr = 3'd0;     bus32.wb_addr = 3'd0;
        bus16.wb_data = 16'd0;    bus32.wb_data = 32'd0;
        bus16.flush = 1'b0;       bus32.flush = 1'b0;
    endtask

    // Random instructions keep register fields in r0..r3 so load-use hits are frequent.
    initial begin
        logic [15:0] cur;
        logic        cur_v, fl, last_fl;
        reset  = 1'b0;
        pc_cnt = 16'd0;
        driveIdle();
        modelClear();
        #100;
        checkZero("reset");
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1'b1, 16'h0400, 1'b0, 3'd0, 32'd0, 1'b0);
        checkOutput("r1_after_reset", 32'(bus16.ex_rd1), 32'd0);

        applyStimulus(1'b0, 16'h0000, 1'b1, 3'd1, 32'd2, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 3'd2, 32'd3, 1'b0);
        applyStimulus(1'b1, 16'h0531, 1'b0, 3'd0, 32'd0, 1'b0);
        checkOutput("add_rd1", 32'(bus16.ex_rd1), 32'd2);
        checkOutput("add_rd2", 32'(bus16.ex_rd2), 32'd3);
        checkOutput("add_rd", 32'(bus16.ex_rd), 32'd3);
        checkOutput("add_ctrl", {29'd0, bus16.regdst, bus16.regwrite, bus16.branch}, 32'b110);
        checkOutput("add_aluop", 32'(bus16.aluop), 32'd2);

        applyStimulus(1'b1, 16'h0531, 1'b1, 3'd1, 32'h000000A5, 1'b0);
        checkOutput("bypass_rd1", 32'(bus16.ex_rd1), 32'h00A5);

        applyStimulus(1'b1, 16'hC0E7, 1'b0, 3'd0, 32'd0, 1'b0);
        checkOutput("lw_imm16", 32'(bus16.ex_imm), 32'h0000FFE7);
        checkOutput("lw_imm32", bus32.ex_imm, 32'hFFFFFFE7);
        applyStimulus(1'b1, 16'h0531, 1'b0, 3'd0, 32'd0, 1'b0);
        checkOutput("loaduse_stall", 32'(last_stall16), 32'd1);
        checkOutput("loaduse_bubble", 32'(bus16.ex_valid), 32'd0);
        applyStimulus(1'b1, 16'h0531, 1'b0, 3'd0, 32'd0, 1'b0);
        checkOutput("loaduse_release", 32'(last_stall16), 32'd0);
        checkOutput("loaduse_issue", 32'(bus16.ex_valid), 32'd1);

        applyStimulus(1'b1, 16'hC0E7, 1'b0, 3'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 16'h0531, 1'b1, 3'd0, 32'h1234, 1'b1);
        checkOutput("flush_stall", 32'(last_stall16), 32'd1);
        checkOutput("flush_bubble", {30'd0, bus16.ex_valid, bus16.regwrite}, 32'd0);
        applyStimulus(1'b1, 16'h0000, 1'b0, 3'd0, 32'd0, 1'b0);
        checkOutput("r0_reads_zero", 32'(bus16.ex_rd1), 32'd0);

        for (int op = 0; op < 8; op++) begin
            applyStimulus(1'b1, 16'(op * 8192 + 16'h0923), 1'b0, 3'd0, 32'd0, 1'b0);
        end

        cur     = 16'd0;
        cur_v   = 1'b0;
        last_fl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(m_stall && !last_fl)) begin
                cur = 16'($urandom_range(0, 7) * 8192 + $urandom_range(0, 3) * 1024 +
                          $urandom_range(0, 3) * 128 + $urandom_range(0, 127));
                cur_v = ($urandom_range(0, 9) != 0);
            end
            fl = ($urandom_range(0, 11) == 0);
            applyStimulus(cur_v, cur, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, fl);
            last_fl = fl;
            if (i == 200) begin
                @(negedge clk);
                #2 reset = 1'b0;
                #1;
                checkZero("midreset");
                modelClear();
                @(negedge clk);
                reset = 1'b1;
                last_fl = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
